// File: rtl/float_to_int_if.sv
// float_to_int_if: stb/ack stream bundle between the FP multiplier result
// stream (input_a side) and the integer consumer (output_z side).
// The master modport is the side that feeds operands and takes results;
// the slave modport is the converter.
interface float_to_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );
endinterface

// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 single precision to 32-bit signed integer.
// One conversion in flight; the mantissa is aligned by an iterative
// one-bit-per-cycle shifter. Default rounding truncates toward zero.
// Optional build macro FLOAT_TO_INT_ROUND_NEAREST_EN switches to
// round-to-nearest-even.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// GET_A    | ack raised, wait for an operand transfer
// UNPACK   | split operand into sign, unbiased exponent, aligned mantissa
// SPECIAL  | inf/NaN/out-of-range saturate, small magnitudes give zero
// SHIFT    | shift mantissa right one bit per cycle until e reaches 31
// ROUND    | apply rounding increment (nearest-even build only)
// PACK     | apply sign, present result
// PUT_Z    | hold result with stb high until downstream acks
module float_to_int #(
    parameter logic [31:0] SAT_VALUE = 32'h80000000
) (
    input  logic         clk,
    input  logic         rst,
    float_to_int_if.slave bus
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        SHIFT   = 3'd3,
        ROUND   = 3'd4,
        PACK    = 3'd5,
        PUT_Z   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        m_q, m_d;
    logic signed [9:0]  e_q, e_d;
    logic               s_q, s_d;
    logic [31:0]        z_q, z_d;
    logic [31:0]        out_q, out_d;
    logic               ack_q, ack_d;
    logic               stb_q, stb_d;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
`endif

    assign bus.input_a_ack  = ack_q;
    assign bus.output_z     = out_q;
    assign bus.output_z_stb = stb_q;

    // State and datapath registers; reset drops both handshakes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            s_q      <= 1'b0;
            z_q      <= '0;
            out_q    <= '0;
            ack_q    <= 1'b0;
            stb_q    <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            e_q      <= e_d;
            s_q      <= s_d;
            z_q      <= z_d;
            out_q    <= out_d;
            ack_q    <= ack_d;
            stb_q    <= stb_d;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

    // Next-state and datapath updates for the conversion sequence.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        e_d      = e_q;
        s_d      = s_q;
        z_d      = z_q;
        out_d    = out_q;
        ack_d    = ack_q;
        stb_d    = stb_q;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif

        case (state_q)
            GET_A: begin
                ack_d = 1'b1;
                if (ack_q && bus.input_a_stb) begin
                    a_d     = bus.input_a;
                    ack_d   = 1'b0;
                    state_d = UNPACK;
                end
            end

            UNPACK: begin
                m_d      = {1'b1, a_q[22:0], 8'b0};
                e_d      = $signed({2'b00, a_q[30:23]}) - 10'sd127;
                s_d      = a_q[31];
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                guard_d  = 1'b0;
                sticky_d = 1'b0;
`endif
                state_d  = SPECIAL;
            end

            SPECIAL: begin
                if (e_q == 10'sd128) begin
                    z_d     = SAT_VALUE;
                    state_d = PUT_Z;
                end else if (e_q > 10'sd30) begin
                    z_d     = SAT_VALUE;
                    state_d = PUT_Z;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                end else if (e_q < -10'sd1) begin
`else
                end else if (e_q < 10'sd0) begin
`endif
                    z_d     = '0;
                    state_d = PUT_Z;
                end else begin
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                // The last shift lands e on 31; move on in the same edge.
                if (e_q < 10'sd31) begin
                    m_d      = m_q >> 1;
                    e_d      = e_q + 10'sd1;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                    guard_d  = m_q[0];
                    sticky_d = sticky_q | guard_q;
`endif
                    if (e_q == 10'sd30) begin
                        state_d = ROUND;
                    end
                end else begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
                if (guard_q && (sticky_q | m_q[0])) begin
                    m_d = m_q + 32'd1;
                end
`endif
                state_d = PACK;
            end

            PACK: begin
                // Result goes straight to the output register so the
                // normal path does not pay an extra PUT_Z cycle.
                z_d     = s_q ? (-m_q) : m_q;
                out_d   = z_d;
                stb_d   = 1'b1;
                state_d = PUT_Z;
            end

            PUT_Z: begin
                if (!stb_q) begin
                    out_d = z_q;
                    stb_d = 1'b1;
                end else if (bus.output_z_ack) begin
                    stb_d   = 1'b0;
                    state_d = GET_A;
                end
            end

            default: begin
                ack_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = GET_A;
            end
        endcase
    end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: driver pushes reference results,
// a monitor pops and compares on every output handshake.
module tb_float_to_int;

    localparam logic [31:0] SAT = 32'h80000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_to_int_if bus_if();

    float_to_int #(.SAT_VALUE(SAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];
    int          ack_mode = 0;     // 0 always, 1 random, 2 manual
    logic        ack_manual = 1'b0;

`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = M * 2^(ex-150) with M the 24-bit significand.
    function automatic logic [31:0] model(input logic [31:0] f);
        int     ex;
        int     sh;
        longint mm;
        longint mag;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
        longint rem;
        longint half;
`endif
        ex = int'(f[30:23]);
        if (ex == 255 || ex >= 158) return SAT;
        if (ex == 0) return 32'h0;
        mm = longint'({1'b1, f[22:0]});
        sh = 150 - ex;
        if (sh <= 0) begin
            mag = mm << (-sh);
        end else if (sh >= 25) begin
            mag = 0;
        end else begin
            mag = mm >> sh;
`ifdef FLOAT_TO_INT_ROUND_NEAREST_EN
            rem  = mm - (mag << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
        end
        return f[31] ? 32'(-mag) : 32'(mag);
    endfunction

    function automatic int lat_of(input logic [31:0] f);
        int e;
        e = int'(f[30:23]) - 127;
        if (e == 128 || e > 30) return 3;
        if (RNE ? (e < -1) : (e < 0)) return 3;
        return 4 + 31 - e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] exp,
                        input bit wait_out, input int exp_lat);
        int n;
        int lat;
        n = 0;
        lat = 0;
        @(posedge clk); #1;
        while (!bus_if.input_a_ack && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_if.input_a_ack) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: input_a_ack 0 required 1");
            return;
        end
        bus_if.input_a     = a;
        bus_if.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus_if.input_a_stb = 1'b0;
        bus_if.input_a     = $urandom;
        sb.push_back(exp);
        check("ack_drop", 32'(bus_if.input_a_ack), 32'd0);
        if (wait_out) begin
            while (!bus_if.output_z_stb && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            if (!bus_if.output_z_stb) begin
                checks++;
                errors++;
                $display("FAIL output_timeout: output_z_stb 0 required 1");
            end else if (exp_lat >= 0) begin
                check("latency", 32'(lat), 32'(exp_lat));
            end
        end
    endtask

    // Downstream ack driver.
    initial begin
        bus_if.output_z_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ack_mode)
                0:       bus_if.output_z_ack = 1'b1;
                1:       bus_if.output_z_ack = 1'($urandom_range(0, 1));
                default: bus_if.output_z_ack = ack_manual;
            endcase
        end
    end

    // Monitor: compare on each handshake, check stability while stalled.
    initial begin
        logic        pstb;
        logic [31:0] pz;
        logic [31:0] exp;
        pstb = 1'b0;
        pz   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstb = 1'b0;
            end else begin
                if (pstb && bus_if.output_z_stb)
                    check("hold_stable", bus_if.output_z, pz);
                if (bus_if.output_z_stb && bus_if.output_z_ack) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", bus_if.output_z);
                    end else begin
                        exp = sb.pop_front();
                        check("result", bus_if.output_z, exp);
                    end
                    pstb = 1'b0;
                end else begin
                    pstb = bus_if.output_z_stb;
                    pz   = bus_if.output_z;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [31:0] dir_a [15];
    logic [31:0] dir_z [15];

    initial begin
        int seen;
        logic [31:0] r;

        dir_a[0]  = 32'h3F800000; dir_z[0]  = 32'h00000001;
        dir_a[1]  = 32'hC2F6E979; dir_z[1]  = 32'hFFFFFF85;
        dir_a[2]  = 32'h3FC00000; dir_z[2]  = RNE ? 32'h2 : 32'h1;
        dir_a[3]  = 32'h40200000; dir_z[3]  = 32'h00000002;
        dir_a[4]  = 32'h7FC00000; dir_z[4]  = 32'h80000000;
        dir_a[5]  = 32'h7F800000; dir_z[5]  = 32'h80000000;
        dir_a[6]  = 32'h4F000000; dir_z[6]  = 32'h80000000;
        dir_a[7]  = 32'hCF000000; dir_z[7]  = 32'h80000000;
        dir_a[8]  = 32'h4EFFFFFF; dir_z[8]  = 32'h7FFFFF80;
        dir_a[9]  = 32'h00000001; dir_z[9]  = 32'h00000000;
        dir_a[10] = 32'h80000000; dir_z[10] = 32'h00000000;
        dir_a[11] = 32'h3F000000; dir_z[11] = 32'h00000000;
        dir_a[12] = 32'h3F400000; dir_z[12] = RNE ? 32'h1 : 32'h0;
        dir_a[13] = 32'hFF800000; dir_z[13] = 32'h80000000;
        dir_a[14] = 32'hBFC00000; dir_z[14] = RNE ? 32'hFFFFFFFE : 32'hFFFFFFFF;

        bus_if.input_a     = '0;
        bus_if.input_a_stb = 1'b0;

        #12;
        check("rst_ack", 32'(bus_if.input_a_ack), 32'd0);
        check("rst_stb", 32'(bus_if.output_z_stb), 32'd0);
        check("rst_z", bus_if.output_z, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ack_after_reset", 32'(bus_if.input_a_ack), 32'd1);

        for (int i = 0; i < 15; i++)
            send(dir_a[i], dir_z[i], 1'b1, lat_of(dir_a[i]));

        // Backpressure: hold ack low 10 cycles with a competing operand.
        #1;
        ack_mode   = 2;
        ack_manual = 1'b0;
        send(32'h40200000, 32'h2, 1'b1, lat_of(32'h40200000));
        bus_if.input_a     = 32'h3F800000;
        bus_if.input_a_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_stb", 32'(bus_if.output_z_stb), 32'd1);
            check("bp_z", bus_if.output_z, 32'h2);
            check("bp_ack", 32'(bus_if.input_a_ack), 32'd0);
        end
        bus_if.input_a_stb = 1'b0;
        ack_manual = 1'b1;
        @(posedge clk); #1;
        check("bp_stb_drop", 32'(bus_if.output_z_stb), 32'd0);
        check("bp_ack_still_low", 32'(bus_if.input_a_ack), 32'd0);
        @(posedge clk); #1;
        check("bp_ack_back", 32'(bus_if.input_a_ack), 32'd1);
        ack_mode = 0;

        // Asynchronous reset in the middle of the shifter.
        send(32'h3F800000, 32'h1, 1'b0, -1);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(bus_if.input_a_ack), 32'd0);
        check("mid_rst_stb", 32'(bus_if.output_z_stb), 32'd0);
        check("mid_rst_z", bus_if.output_z, 32'd0);
        void'(sb.pop_back());
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.output_z_stb) seen++;
        end
        check("no_output_after_reset", 32'(seen), 32'd0);
        send(32'h41200000, 32'h0000000A, 1'b1, lat_of(32'h41200000));

        // Randomized operands, biased toward the interesting exponent band.
        for (int i = 0; i < 250; i++) begin
            ack_mode = (i % 3 == 0) ? 0 : 1;
            r = $urandom;
            if ($urandom_range(0, 3) != 0)
                r[30:23] = 8'($urandom_range(118, 160));
            send(r, model(r), 1'b1, lat_of(r));
        end

        ack_mode = 0;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
